// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead FIFO and serialises each word as a
// UART frame (start bit, LSB-first data, stop bits), one pop per frame.
module fifo_uart_tx #(
    parameter int width     = 8,
    parameter int clk_div   = 868,
    parameter int stop_bits = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_read_data,
    output logic             fifo_pop,
    output logic             tx,
    output logic             busy
);
    localparam int CW = $clog2(clk_div);
    localparam int BW = $clog2(width + stop_bits);

    localparam logic [CW-1:0] C_LAST = CW'(clk_div - 1);
    localparam logic [BW-1:0] B_LAST = BW'(width - 1);
    localparam logic [BW-1:0] S_LAST = BW'(stop_bits - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state, w_nstate;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [BW-1:0]    r_bit, w_bit;
    logic [width-1:0] r_sh, w_sh, w_shifted;
    logic             r_tx, w_tx;
    logic             r_busy;
    logic             w_bit_end, w_last_stop, w_start;

    assign w_bit_end   = (r_state != IDLE) && (r_cnt == C_LAST);
    assign w_last_stop = (r_bit == S_LAST);
    assign w_shifted   = r_sh >> 1;

    // Reset gates the pop so a held reset never consumes a word
    assign w_start = tx_en & ~fifo_empty & ~rst &
                     ((r_state == IDLE) |
                      ((r_state == STOP) & w_bit_end & w_last_stop));

    assign fifo_pop = w_start;
    assign tx       = r_tx;
    assign busy     = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_sh    <= w_sh;
            r_tx    <= w_tx;
            r_busy  <= (w_nstate != IDLE);
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_cnt    = (r_state == IDLE) ? '0 : r_cnt + CW'(1);
        w_bit    = r_bit;
        w_sh     = r_sh;
        w_tx     = r_tx;
        if (w_bit_end)
            w_cnt = '0;

        unique case (r_state)
            IDLE: begin
                w_tx = 1'b1;
            end
            START: begin
                if (w_bit_end) begin
                    w_nstate = DATA;
                    w_bit    = '0;
                    w_tx     = r_sh[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit == B_LAST) begin
                        w_nstate = STOP;
                        w_bit    = '0;
                        w_tx     = 1'b1;
                    end else begin
                        w_sh  = w_shifted;
                        w_bit = r_bit + BW'(1);
                        w_tx  = w_shifted[0];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (w_last_stop)
                        w_nstate = IDLE;
                    else
                        w_bit = r_bit + BW'(1);
                end
            end
            default: w_nstate = IDLE;
        endcase

        // A new frame overrides the idle/stop path in the same cycle
        if (w_start) begin
            w_nstate = START;
            w_sh     = fifo_read_data;
            w_cnt    = '0;
            w_bit    = '0;
            w_tx     = 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of framing, pop timing, tx_en gating,
// reset and two-stop-bit operation with clk_div=4.
module tb_fifo_uart_tx;
    logic       clk;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rd;
    logic       pop;
    logic       tx;
    logic       busy;

    logic       tx_en2;
    logic       empty2;
    logic [7:0] data2;
    logic       pop2;
    logic       tx2;
    logic       busy2;

    logic [7:0] mem [0:15];
    int         wr;
    int         rd;
    int         pops;
    int         checks;
    int         passes;
    int         p0;

    fifo_uart_tx #(.width(8), .clk_div(4), .stop_bits(1)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_rd), .fifo_pop(pop), .tx(tx), .busy(busy)
    );

    fifo_uart_tx #(.width(8), .clk_div(4), .stop_bits(2)) dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_empty(empty2),
        .fifo_read_data(data2), .fifo_pop(pop2), .tx(tx2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (wr == rd);
    assign fifo_rd    = mem[rd[3:0]];

    always @(posedge clk) begin
        if (pop) begin
            rd   <= rd + 1;
            pops <= pops + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr[3:0]] = d;
        wr = wr + 1;
    endtask

    // bit slot b: 0 start, 1..8 data LSB first, then stop/idle high
    function automatic logic exp_tx(input logic [7:0] d, input int c);
        int b;
        b = (c - 1) / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    task automatic frame(input logic [7:0] d, input logic nxt,
                         input int drop);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == drop) begin
                tx_en = 1'b0;
                #1;
            end
            chk("frame_tx", c, 32'(tx), 32'(exp_tx(d, c)));
            chk("frame_busy", c, 32'(busy), 32'd1);
            chk("frame_pop", c, 32'(pop), (c == 40) ? 32'(nxt) : 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 1; c <= n; c++) begin
            tick();
            chk("idle_tx", c, 32'(tx), 32'd1);
            chk("idle_busy", c, 32'(busy), 32'd0);
            chk("idle_pop", c, 32'(pop), 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        wr     = 0;
        rd     = 0;
        pops   = 0;
        rst    = 1'b1;
        tx_en  = 1'b1;
        tx_en2 = 1'b0;
        empty2 = 1'b1;
        data2  = 8'h00;

        // 1: reset and idle with empty FIFO
        repeat (3) tick();
        chk("rst_tx", 0, 32'(tx), 32'd1);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_pop", 0, 32'(pop), 32'd0);
        chk("rst_tx2", 0, 32'(tx2), 32'd1);
        rst = 1'b0;
        idle(50);

        // 2: single word 0xA5
        push(8'hA5);
        #1;
        chk("a5_pop0", 0, 32'(pop), 32'd1);
        frame(8'hA5, 1'b0, 0);
        idle(4);
        chk("a5_pops", 0, 32'(pops), 32'd1);

        // 3: back-to-back 0x00, 0xFF
        push(8'h00);
        push(8'hFF);
        #1;
        chk("b2b_pop0", 0, 32'(pop), 32'd1);
        frame(8'h00, 1'b1, 0);
        frame(8'hFF, 1'b0, 0);
        idle(4);
        chk("b2b_pops", 0, 32'(pops), 32'd3);

        // 4: tx_en dropped mid-frame with words queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        #1;
        chk("en_pop0", 0, 32'(pop), 32'd1);
        frame(8'h11, 1'b0, 10);
        idle(20);
        tx_en = 1'b1;
        #1;
        chk("en_rise_pop", 0, 32'(pop), 32'd1);
        frame(8'h22, 1'b1, 0);
        frame(8'h33, 1'b0, 0);
        idle(4);
        chk("en_pops", 0, 32'(pops), 32'd6);

        // 5: reset during data bit 3
        push(8'h5A);
        #1;
        chk("mr_pop0", 0, 32'(pop), 32'd1);
        for (int c = 1; c <= 18; c++) begin
            tick();
            chk("mr_tx", c, 32'(tx), 32'(exp_tx(8'h5A, c)));
        end
        push(8'hC3);
        rst = 1'b1;
        #1;
        chk("mr_tx_rst", 0, 32'(tx), 32'd1);
        chk("mr_busy_rst", 0, 32'(busy), 32'd0);
        chk("mr_pop_rst", 0, 32'(pop), 32'd0);
        p0 = pops;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("mr_pop_hold", c, 32'(pop), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("mr_pop_rel", 0, 32'(pop), 32'd1);
        chk("mr_pops_rel", 0, 32'(pops), 32'(p0));
        frame(8'hC3, 1'b0, 0);
        idle(4);
        chk("mr_pops", 0, 32'(pops), 32'(p0 + 1));

        // 6: two stop bits, 44-cycle frame
        data2  = 8'h3C;
        empty2 = 1'b0;
        tx_en2 = 1'b1;
        #1;
        chk("sb2_pop0", 0, 32'(pop2), 32'd1);
        for (int c = 1; c <= 44; c++) begin
            tick();
            if (c == 1) begin
                data2 = 8'h96;
                #1;
            end
            chk("sb2_tx", c, 32'(tx2), 32'(exp_tx(8'h3C, c)));
            chk("sb2_busy", c, 32'(busy2), 32'd1);
            chk("sb2_pop", c, 32'(pop2), (c == 44) ? 32'd1 : 32'd0);
        end
        tick();
        empty2 = 1'b1;
        tx_en2 = 1'b0;
        #1;
        chk("sb2_next_start", 45, 32'(tx2), 32'd0);
        chk("sb2_next_busy", 45, 32'(busy2), 32'd1);
        for (int c = 2; c <= 44; c++) begin
            tick();
            chk("sb2_f2_tx", c, 32'(tx2), 32'(exp_tx(8'h96, c)));
            chk("sb2_f2_pop", c, 32'(pop2), 32'd0);
        end
        tick();
        chk("sb2_end_busy", 0, 32'(busy2), 32'd0);
        chk("sb2_end_tx", 0, 32'(tx2), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
